// File: rtl/multi_byte_rx_pkg.sv
// Shared UART word-assembly definitions: FSM state type and the helpers that
// derive byte-count and counter widths from the word width and timeout.
package multi_byte_rx_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } rx_state_t;

  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  function automatic int nbytes_f(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int bcnt_w_f(input int data_width);
    return clog2_min1(data_width / 8);
  endfunction

  function automatic int tcnt_w_f(input int timeout_cycles);
    return clog2_min1(timeout_cycles);
  endfunction

endpackage

// File: rtl/multi_byte_rx_timeout_cnt.sv
// Clearable, enabled inter-byte gap counter with a single-cycle expiry flag.
module rx_timeout_cnt #(
  parameter int LIMIT = 1000,
  parameter int W     = 10
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Raised in the cycle whose increment takes the count onto LIMIT-1.
  assign expired = en && !clr && (count_reg == W'(LIMIT - 2));

endmodule

// File: rtl/multi_byte_rx.sv
// Packs NBYTES consecutive received bytes into one word; partial words are
// dropped on an inter-byte timeout or a framing error.
module multi_byte_rx
  import multi_byte_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter bit MSB_1st        = 1'b1,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_done,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_frame_err,
  output logic [DATA_WIDTH-1:0] multi_byte_data_out,
  output logic                  multi_byte_rx_done,
  output logic                  rx_busy,
  output logic                  rx_err
);

  localparam int NBYTES = nbytes_f(DATA_WIDTH);
  localparam int BCNT_W = bcnt_w_f(DATA_WIDTH);
  localparam int TCNT_W = tcnt_w_f(TIMEOUT_CYCLES);
  localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(NBYTES - 1);

  rx_state_t             state_reg, state_next;
  logic [BCNT_W-1:0]     bcnt_reg, bcnt_next;
  logic [DATA_WIDTH-1:0] asm_reg, asm_next;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;
  logic                  busy_reg;
  logic                  load_word;
  logic                  accept, abort, expired;

  assign accept = rx_done && !rx_frame_err;
  assign abort  = rx_done && rx_frame_err;

  rx_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TCNT_W)
  ) u_tcnt (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (rx_done || (state_reg == IDLE)),
    .en      (state_reg == COLLECT),
    .expired (expired)
  );

  // Each byte lane of the word knows which arrival index it captures.
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
      localparam int K = MSB_1st ? (NBYTES - 1 - gi) : gi;
      assign asm_next[8*gi +: 8] = (accept && (bcnt_reg == BCNT_W'(K)))
                                   ? rx_byte : asm_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    bcnt_next  = bcnt_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    load_word  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (abort) begin
          err_next = 1'b1;
        end else if (accept) begin
          state_next = COLLECT;
          bcnt_next  = BCNT_W'(1);
        end
      end
      COLLECT: begin
        if (abort) begin
          err_next   = 1'b1;
          state_next = IDLE;
          bcnt_next  = '0;
        end else if (accept) begin
          if (bcnt_reg == LAST_IDX) begin
            load_word  = 1'b1;
            done_next  = 1'b1;
            state_next = IDLE;
            bcnt_next  = '0;
          end else begin
            bcnt_next = bcnt_reg + 1'b1;
          end
        end else if (expired) begin
          err_next   = 1'b1;
          state_next = IDLE;
          bcnt_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
        bcnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      bcnt_reg  <= '0;
      asm_reg   <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      bcnt_reg  <= bcnt_next;
      // Leaving COLLECT for any reason empties the assembly register.
      asm_reg   <= (state_next == IDLE) ? '0 : asm_next;
      if (load_word) begin
        data_reg <= asm_next;
      end
      done_reg  <= done_next;
      err_reg   <= err_next;
      busy_reg  <= (state_next == COLLECT);
    end
  end

  assign multi_byte_data_out = data_reg;
  assign multi_byte_rx_done  = done_reg;
  assign rx_busy             = busy_reg;
  assign rx_err              = err_reg;

endmodule
